// File: rtl/cfg_strobe_pkg.sv
// cfg_strobe_pkg: shared state type, phase-counter width and one-hot helper for frame strobing
package cfg_strobe_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int CNT_W = 4;
  localparam int MAX_ONEHOT = 64;
  function automatic logic [MAX_ONEHOT-1:0] onehot_vec(input int unsigned idx);
    return {{(MAX_ONEHOT-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/frame_onehot_decode.sv
// frame_onehot_decode: enabled index to one-hot decoder, zero when disabled or index out of range
module frame_onehot_decode
  import cfg_strobe_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameIdxBits = 5
) (
  input  logic                       en,
  input  logic [FrameIdxBits-1:0]    idx,
  output logic [MaxFramesPerCol-1:0] onehot
);
  assign onehot = en ? MaxFramesPerCol'(onehot_vec(32'(idx))) : '0;
endmodule

// File: rtl/column_frame_strobe_gen.sv
// column_frame_strobe_gen: turns accepted frame-write commands into setup/strobe/hold timed one-hot strobes
module column_frame_strobe_gen
  import cfg_strobe_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int ColumnID = 0,
  parameter int ColBits = 5,
  parameter int FrameIdxBits = 5,
  parameter int SetupCycles = 1,
  parameter int StrobeCycles = 2,
  parameter int HoldCycles = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ColBits-1:0]         cmd_col,
  input  logic [FrameIdxBits-1:0]    cmd_frame,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_range
);
  if (SetupCycles < 1 || SetupCycles > 15 || StrobeCycles < 1 || StrobeCycles > 15 ||
      HoldCycles < 1 || HoldCycles > 15 || MaxFramesPerCol < 1 || MaxFramesPerCol > MAX_ONEHOT ||
      (2 ** FrameIdxBits) < MaxFramesPerCol || ColumnID < 0 || ColumnID >= (2 ** ColBits)) begin : g_bad_cfg
    $error("column_frame_strobe_gen: illegal parameter configuration");
  end
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [FrameIdxBits-1:0] frame_q;
  logic                    hit;
  assign hit = cmd_valid && cmd_col == ColBits'(ColumnID);
  assign cmd_ready = state == IDLE && resetn;
  assign busy = state != IDLE;
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      frame_q <= '0;
      err_range <= 1'b0;
    end else begin
      err_range <= 1'b0;
      case (state)
        IDLE:
          if (hit) begin
            if (32'(cmd_frame) >= 32'(MaxFramesPerCol)) err_range <= 1'b1;
            else begin
              frame_q <= cmd_frame;
              cnt <= CNT_W'(SetupCycles - 1);
              state <= SETUP;
            end
          end
        SETUP:
          if (cnt == '0) begin
            cnt <= CNT_W'(StrobeCycles - 1);
            state <= STROBE;
          end else cnt <= cnt - 1'b1;
        STROBE:
          if (cnt == '0) begin
            cnt <= CNT_W'(HoldCycles - 1);
            state <= HOLD;
          end else cnt <= cnt - 1'b1;
        HOLD:
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
      endcase
    end
  end
  frame_onehot_decode #(.MaxFramesPerCol(MaxFramesPerCol), .FrameIdxBits(FrameIdxBits)) u_dec (
    .en(state == STROBE),
    .idx(frame_q),
    .onehot(FrameStrobe)
  );
endmodule

// File: tb/tb_column_frame_strobe_gen.sv
// tb_column_frame_strobe_gen: directed plus random checks of two strobe generator configurations
module tb_column_frame_strobe_gen;
  logic UserCLK = 1'b0, resetn = 1'b0, cmd_valid = 1'b0;
  logic [4:0] cmd_col = '0, cmd_frame = '0;
  logic [19:0] fs0, fs1;
  logic rdy0, rdy1, busy0, busy1, err0, err1;
  int errors = 0, checks = 0;
  int sc[2] = '{1, 3};
  int tc[2] = '{2, 1};
  int hc[2] = '{1, 2};
  bit act[2] = '{0, 0};
  bit er[2] = '{0, 0};
  int el[2] = '{0, 0};
  int idx[2] = '{0, 0};
  always #5 UserCLK = ~UserCLK;
  column_frame_strobe_gen dut0 (
    .UserCLK(UserCLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .FrameStrobe(fs0), .busy(busy0), .err_range(err0)
  );
  column_frame_strobe_gen #(.SetupCycles(3), .StrobeCycles(1), .HoldCycles(2)) dut1 (
    .UserCLK(UserCLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .FrameStrobe(fs1), .busy(busy1), .err_range(err1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_fs(input int i);
    return (act[i] && el[i] >= sc[i] && el[i] < sc[i] + tc[i]) ? (32'd1 << idx[i]) : 32'd0;
  endfunction
  // Model: a sequence is just the number of edges elapsed since its accepting edge.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        act[i] = 0;
        er[i] = 0;
      end else begin
        er[i] = 0;
        if (act[i]) begin
          el[i]++;
          if (el[i] == sc[i] + tc[i] + hc[i]) act[i] = 0;
        end else if (cmd_valid && cmd_col == 5'd0) begin
          if (cmd_frame >= 5'd20) er[i] = 1;
          else begin
            act[i] = 1;
            el[i] = 0;
            idx[i] = int'(cmd_frame);
          end
        end
      end
    end
    @(posedge UserCLK);
    #1;
    chk("fs0", 32'(fs0), exp_fs(0));
    chk("busy0", 32'(busy0), 32'(act[0]));
    chk("rdy0", 32'(rdy0), 32'(!act[0] && resetn));
    chk("err0", 32'(err0), 32'(er[0]));
    chk("fs1", 32'(fs1), exp_fs(1));
    chk("busy1", 32'(busy1), 32'(act[1]));
    chk("rdy1", 32'(rdy1), 32'(!act[1] && resetn));
    chk("err1", 32'(err1), 32'(er[1]));
  endtask
  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic send(input logic [4:0] col, input logic [4:0] frame);
    cmd_valid = 1'b1;
    cmd_col = col;
    cmd_frame = frame;
    step();
    cmd_valid = 1'b0;
  endtask
  initial begin
    bit got19;
    idle(2);
    resetn = 1'b1;
    idle(1);
    send(5'd0, 5'd5);
    step();
    chk("frame5_rise", 32'(fs0), 32'h00020);
    step();
    chk("frame5_hold", 32'(fs0), 32'h00020);
    idle(7);
    send(5'd3, 5'd5);
    idle(1);
    send(5'd0, 5'd20);
    chk("err_f20", 32'(err0), 32'd1);
    idle(1);
    send(5'd0, 5'd31);
    idle(2);
    cmd_valid = 1'b1;
    cmd_col = 5'd0;
    cmd_frame = 5'd0;
    got19 = 0;
    for (int i = 0; i < 40 && !got19; i++) begin
      step();
      if (act[0] && el[0] == 0) begin
        if (cmd_frame == 5'd19) got19 = 1;
        else cmd_frame = 5'd19;
      end
    end
    chk("b2b_accept19", 32'(got19), 32'd1);
    idle(8);
    send(5'd0, 5'd7);
    step();
    step();
    chk("frame7_strobe", 32'(fs0), 32'h00080);
    resetn = 1'b0;
    step();
    chk("rst_fs", 32'(fs0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    resetn = 1'b1;
    idle(1);
    send(5'd0, 5'd2);
    idle(8);
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_col = 5'($urandom_range(0, 3));
      cmd_frame = 5'($urandom_range(0, 31));
      resetn = ($urandom_range(0, 63) != 0);
      step();
    end
    resetn = 1'b1;
    idle(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
